rpn_lan_from_network_bridge_router: RTL and testbench

Parametrised, registered packet router between the network bridge and the RPN LAN reliability blocks (sequence-number initializer, LAN TX, LAN RX, and future consumers). It classifies each AXIS packet on its head beat by comparing the RPN message-type field against a per-output match table. It then locks the route until `tlast` and forwards the whole packet to exactly one output through a one-stage pipeline register. Packets with no match are consumed and discarded, and the drop is counted.

---
 rtl/rpn_lan_from_network_bridge_router.sv | 183 ++++++++++++++++++
 tb/tb_rpn_lan_from_network_bridge_router.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_lan_from_network_bridge_router.sv
// Packet router from the network bridge to the RPN LAN reliability blocks.
// Each packet is classified on its head beat by its RPN message type. The
// route is then locked until tlast, and the packet is forwarded to exactly one
// output through a single pipeline register. Packets with no match are
// discarded, and the discards are counted.
module rpn_lan_from_network_bridge_router #(
    parameter int AXIS_DATA_WIDTH    = 64,
    parameter int AXIS_KEEP_WIDTH    = 8,
    parameter int AXIS_TID_WIDTH     = 8,
    parameter int AXIS_TDEST_WIDTH   = 8,
    parameter int AXIS_TUSER_WIDTH   = 32,
    parameter int NUM_OUTPUTS        = 3,
    parameter int RPN_MSG_TYPE_WIDTH = 8,
    parameter int DROP_CNT_WIDTH     = 16
) (
    input  logic                                         i_clk,
    input  logic                                         i_ap_rst,
    input  logic [NUM_OUTPUTS*RPN_MSG_TYPE_WIDTH-1:0]    i_route_msg_type,
    input  logic [NUM_OUTPUTS-1:0]                       i_route_enable,
    input  logic                                         from_network_bridge_tvalid,
    output logic                                         from_network_bridge_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]                   from_network_bridge_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]                   from_network_bridge_tkeep,
    input  logic [AXIS_TID_WIDTH-1:0]                    from_network_bridge_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0]                  from_network_bridge_tdest,
    input  logic [AXIS_TUSER_WIDTH-1:0]                  from_network_bridge_tuser,
    input  logic                                         from_network_bridge_tlast,
    output logic [NUM_OUTPUTS-1:0]                       to_out_tvalid,
    input  logic [NUM_OUTPUTS-1:0]                       to_out_tready,
    output logic [AXIS_DATA_WIDTH-1:0]                   to_out_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]                   to_out_tkeep,
    output logic [AXIS_TID_WIDTH-1:0]                    to_out_tid,
    output logic [AXIS_TDEST_WIDTH-1:0]                  to_out_tdest,
    output logic [AXIS_TUSER_WIDTH-1:0]                  to_out_tuser,
    output logic                                         to_out_tlast,
    output logic [DROP_CNT_WIDTH-1:0]                    o_drop_count,
    output logic                                         o_drop_pulse
);

    localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    typedef enum logic [1:0] {HEAD, FWD, DROP} state_t;

    state_t                      state, state_next;
    logic [SEL_W-1:0]            sel, out_sel, hit_idx;
    logic                        hit, out_valid, sel_ready, in_ready;
    logic                        accept, fwd_load, drop_head;
    logic [AXIS_DATA_WIDTH-1:0]  tdata_p1;
    logic [AXIS_KEEP_WIDTH-1:0]  tkeep_p1;
    logic [AXIS_TID_WIDTH-1:0]   tid_p1;
    logic [AXIS_TDEST_WIDTH-1:0] tdest_p1;
    logic [AXIS_TUSER_WIDTH-1:0] tuser_p1;
    logic                        tlast_p1;

    // Saturating increment: the drop counter sticks at all-ones.
    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] c);
        return (&c) ? c : c + DROP_CNT_WIDTH'(1);
    endfunction

    // Match the head beat's message type; the lowest enabled matching entry wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
            if (i_route_enable[k] &&
                from_network_bridge_tdata[RPN_MSG_TYPE_WIDTH-1:0] ==
                i_route_msg_type[k*RPN_MSG_TYPE_WIDTH +: RPN_MSG_TYPE_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    // Ready of the output that currently owns the held beat.
    always_comb begin
        sel_ready = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (out_sel == SEL_W'(k)) sel_ready = to_out_tready[k];
        end
    end

    // Input ready, handshake decode and next state. Discards bypass the
    // pipeline register, so they never wait on a stalled output.
    always_comb begin
        state_next = state;
        fwd_load   = 1'b0;
        drop_head  = 1'b0;
        case (state)
            HEAD:    in_ready = hit ? (!out_valid || sel_ready) : 1'b1;
            FWD:     in_ready = !out_valid || sel_ready;
            default: in_ready = 1'b1;
        endcase
        if (i_ap_rst) in_ready = 1'b0;
        accept = from_network_bridge_tvalid && in_ready;
        if (accept) begin
            case (state)
                HEAD: begin
                    if (hit) begin
                        fwd_load = 1'b1;
                        if (!from_network_bridge_tlast) state_next = FWD;
                    end else begin
                        drop_head = 1'b1;
                        if (!from_network_bridge_tlast) state_next = DROP;
                    end
                end
                FWD: begin
                    fwd_load = 1'b1;
                    if (from_network_bridge_tlast) state_next = HEAD;
                end
                default: begin
                    if (from_network_bridge_tlast) state_next = HEAD;
                end
            endcase
        end
    end

    assign from_network_bridge_tready = in_ready;

    // State register.
    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) state <= HEAD;
        else          state <= state_next;
    end

    // Route lock: the port is latched only on an accepted, matched head.
    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst)                      sel <= '0;
        else if (state == HEAD && fwd_load) sel <= hit_idx;
    end

    // Stage p1: output pipeline register. A load and a drain in the same
    // cycle keep out_valid high and replace the payload.
    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
            tdata_p1  <= '0;
            tkeep_p1  <= '0;
            tid_p1    <= '0;
            tdest_p1  <= '0;
            tuser_p1  <= '0;
            tlast_p1  <= 1'b0;
        end else if (fwd_load) begin
            out_valid <= 1'b1;
            out_sel   <= (state == HEAD) ? hit_idx : sel;
            tdata_p1  <= from_network_bridge_tdata;
            tkeep_p1  <= from_network_bridge_tkeep;
            tid_p1    <= from_network_bridge_tid;
            tdest_p1  <= from_network_bridge_tdest;
            tuser_p1  <= from_network_bridge_tuser;
            tlast_p1  <= from_network_bridge_tlast;
        end else if (out_valid && sel_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Drop accounting, visible the cycle after the discarded head is accepted.
    always_ff @(posedge i_clk or posedge i_ap_rst) begin
        if (i_ap_rst) begin
            o_drop_pulse <= 1'b0;
            o_drop_count <= '0;
        end else begin
            o_drop_pulse <= drop_head;
            if (drop_head) o_drop_count <= sat_inc(o_drop_count);
        end
    end

    // Fan the held beat's valid out to its owning output only.
    always_comb begin
        to_out_tvalid = '0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            to_out_tvalid[k] = out_valid && (out_sel == SEL_W'(k));
        end
    end

    assign to_out_tdata  = tdata_p1;
    assign to_out_tkeep  = tkeep_p1;
    assign to_out_tid    = tid_p1;
    assign to_out_tdest  = tdest_p1;
    assign to_out_tuser  = tuser_p1;
    assign to_out_tlast  = tlast_p1;

endmodule

// File: tb/tb_rpn_lan_from_network_bridge_router.sv
// Bench for rpn_lan_from_network_bridge_router: table-driven single-beat
// routing vectors, directed multi-cycle sequences, and a randomized run
// checked against a packet-level reference model.
module tb_rpn_lan_from_network_bridge_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] tbl;
    logic [2:0]  en;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep, s_tid, s_tdest;
    logic [31:0] s_tuser;
    logic [2:0]  o_tvalid, o_tready;
    logic [63:0] o_tdata;
    logic [7:0]  o_tkeep, o_tid, o_tdest;
    logic [31:0] o_tuser;
    logic        o_tlast;
    logic [15:0] drop_count;
    logic        drop_pulse;

    int total = 0;
    int bad = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    rpn_lan_from_network_bridge_router #(
        .AXIS_DATA_WIDTH(64), .AXIS_KEEP_WIDTH(8), .AXIS_TID_WIDTH(8),
        .AXIS_TDEST_WIDTH(8), .AXIS_TUSER_WIDTH(32), .NUM_OUTPUTS(3),
        .RPN_MSG_TYPE_WIDTH(8), .DROP_CNT_WIDTH(16)
    ) dut (
        .i_clk(clk), .i_ap_rst(rst),
        .i_route_msg_type(tbl), .i_route_enable(en),
        .from_network_bridge_tvalid(s_tvalid), .from_network_bridge_tready(s_tready),
        .from_network_bridge_tdata(s_tdata), .from_network_bridge_tkeep(s_tkeep),
        .from_network_bridge_tid(s_tid), .from_network_bridge_tdest(s_tdest),
        .from_network_bridge_tuser(s_tuser), .from_network_bridge_tlast(s_tlast),
        .to_out_tvalid(o_tvalid), .to_out_tready(o_tready),
        .to_out_tdata(o_tdata), .to_out_tkeep(o_tkeep), .to_out_tid(o_tid),
        .to_out_tdest(o_tdest), .to_out_tuser(o_tuser), .to_out_tlast(o_tlast),
        .o_drop_count(drop_count), .o_drop_pulse(drop_pulse)
    );

    typedef struct {
        logic [23:0] tbl;
        logic [2:0]  en;
        logic [7:0]  msg;
        logic [7:0]  keep;
        logic [7:0]  id;
        logic [31:0] user;
        logic [2:0]  exp_vld;
    } vec_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        logic        last;
    } beat_t;

    vec_t  vecs[8];
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_beat(input logic [63:0] data, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = last;
    endtask

    // First enabled entry whose type equals the head's type, or -1 for a drop.
    function automatic int ref_route(input logic [23:0] t, input logic [2:0] e, input logic [7:0] m);
        for (int k = 0; k < 3; k++) begin
            if (e[k] && t[k*8 +: 8] == m) return k;
        end
        return -1;
    endfunction

    initial begin
        logic [63:0] prev, b0, b1, h2, hi;
        logic        rdy[4];
        logic [7:0]  picks[5];
        beat_t       e;
        int          pkt_left, cyc, stall, pulses, port_m, drops_before;
        bit          in_pkt, hs, done;

        rst = 1'b1; tbl = 24'h030201; en = 3'b111;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = 8'hFF; s_tid = '0; s_tdest = '0;
        s_tuser = '0; s_tlast = 1'b0; o_tready = 3'b111;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", o_tvalid, 3'b000);
        chk("rst_tready", s_tready, 1'b0);
        chk("rst_drop_count", drop_count, 16'd0);
        chk("rst_drop_pulse", drop_pulse, 1'b0);
        rst = 1'b0;

        // ---------------- table-driven single-beat packets ----------------
        vecs[0] = '{24'h030201, 3'b111, 8'h02, 8'h0A, 8'hEE, 32'hAAAABBBB, 3'b010};
        vecs[1] = '{24'h030201, 3'b111, 8'h01, 8'hFF, 8'h11, 32'h00000001, 3'b001};
        vecs[2] = '{24'h030201, 3'b111, 8'h03, 8'h0F, 8'h22, 32'h12345678, 3'b100};
        vecs[3] = '{24'h030201, 3'b111, 8'h55, 8'hFF, 8'h33, 32'h0, 3'b000};
        vecs[4] = '{24'h040404, 3'b110, 8'h04, 8'h01, 8'h44, 32'hDEADBEEF, 3'b010};
        vecs[5] = '{24'h040404, 3'b111, 8'h04, 8'h03, 8'h55, 32'hCAFEF00D, 3'b001};
        vecs[6] = '{24'h030201, 3'b000, 8'h01, 8'hFF, 8'h66, 32'h0, 3'b000};
        vecs[7] = '{24'h090907, 3'b111, 8'h09, 8'h80, 8'h77, 32'h87654321, 3'b010};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tbl = vecs[i].tbl; en = vecs[i].en;
            s_tkeep = vecs[i].keep; s_tid = vecs[i].id; s_tuser = vecs[i].user;
            hi = {48'hC0FFEE000000, 8'(i), vecs[i].msg};
            set_beat(hi, 1'b1);
            #1 chk("vec_tready", s_tready, 1'b1);
            @(negedge clk);
            s_tvalid = 1'b0;
            if (vecs[i].exp_vld == 3'b000) exp_drops++;
            chk("vec_tvalid", o_tvalid, vecs[i].exp_vld);
            chk("vec_drop_pulse", drop_pulse, vecs[i].exp_vld == 3'b000);
            chk("vec_drop_count", drop_count, exp_drops);
            if (vecs[i].exp_vld != 3'b000) begin
                chk("vec_tdata", o_tdata, hi);
                chk("vec_tkeep", o_tkeep, vecs[i].keep);
                chk("vec_tid", o_tid, vecs[i].id);
                chk("vec_tuser", o_tuser, vecs[i].user);
                chk("vec_tlast", o_tlast, 1'b1);
            end
        end
        s_tkeep = 8'hFF; s_tid = '0; s_tuser = '0;
        tbl = 24'h030201; en = 3'b111;

        // ---------------- route lock across a table rewrite ----------------
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 1) tbl[23:16] = 8'h07;
            if (i > 0) begin
                chk("lock_tvalid", o_tvalid, 3'b100);
                chk("lock_tdata", o_tdata, prev);
                chk("lock_tlast", o_tlast, 1'b0);
            end
            prev = {48'h0, 8'(i), (i == 0) ? 8'h03 : 8'h01};
            set_beat(prev, i == 3);
            #1 chk("lock_tready", s_tready, 1'b1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("lock_last_tvalid", o_tvalid, 3'b100);
        chk("lock_last_tdata", o_tdata, prev);
        chk("lock_last_tlast", o_tlast, 1'b1);
        tbl = 24'h030201;

        // ---------------- drop while output 0 is stalled ----------------
        @(negedge clk);
        o_tready = 3'b110;
        set_beat(64'h1111_0000_0000_0001, 1'b1);
        @(negedge clk);
        chk("drop_held_tvalid", o_tvalid, 3'b001);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 1) chk("drop_pulse_on", drop_pulse, 1'b1);
            if (i == 2) chk("drop_pulse_off", drop_pulse, 1'b0);
            set_beat({56'h2222, (i == 0) ? 8'h55 : 8'h01}, i == 2);
            #1 chk("drop_tready", s_tready, 1'b1);
            chk("drop_no_new_tvalid", o_tvalid, 3'b001);
        end
        exp_drops++;
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("drop_count", drop_count, exp_drops);
        chk("drop_held_still", o_tdata, 64'h1111_0000_0000_0001);
        o_tready = 3'b111;
        @(negedge clk);
        chk("drop_drained", o_tvalid, 3'b000);

        // ---------------- back-pressure and ordering ----------------
        b0 = {48'h0, 8'hB0, 8'h01};
        b1 = {48'h0, 8'hB1, 8'h01};
        h2 = {48'h0, 8'hB2, 8'h03};
        rdy[0] = 1'b1; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            o_tready = {2'b11, rdy[i]};
            if (i > 0) begin
                chk("bp_tvalid", o_tvalid, 3'b001);
                chk("bp_hold", o_tdata, b0);
            end
            set_beat((i == 0) ? b0 : b1, i != 0);
            #1 chk("bp_tready", s_tready, rdy[i]);
        end
        @(negedge clk);
        o_tready = 3'b110;
        chk("bp_b1_tvalid", o_tvalid, 3'b001);
        chk("bp_b1_data", o_tdata, b1);
        chk("bp_b1_last", o_tlast, 1'b1);
        set_beat(h2, 1'b1);
        #1 chk("bp_head_wait", s_tready, 1'b0);
        @(negedge clk);
        o_tready = 3'b111;
        chk("bp_b1_stable", o_tdata, b1);
        #1 chk("bp_head_accept", s_tready, 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("bp_h2_tvalid", o_tvalid, 3'b100);
        chk("bp_h2_data", o_tdata, h2);
        @(negedge clk);
        chk("bp_idle", o_tvalid, 3'b000);

        // ---------------- reset mid-packet ----------------
        set_beat({56'h3300, 8'h02}, 1'b0);
        @(negedge clk);
        chk("rstmid_pre_tvalid", o_tvalid, 3'b010);
        set_beat({56'h3301, 8'h02}, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstmid_tvalid", o_tvalid, 3'b000);
        chk("rstmid_drop_count", drop_count, 16'd0);
        chk("rstmid_tready", s_tready, 1'b0);
        exp_drops = 0;
        @(negedge clk);
        rst = 1'b0;
        set_beat({56'h3302, 8'h01}, 1'b1);
        #1 chk("rstmid_head_tready", s_tready, 1'b1);
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("rstmid_head_tvalid", o_tvalid, 3'b001);
        chk("rstmid_head_data", o_tdata, {56'h3302, 8'h01});
        chk("rstmid_head_last", o_tlast, 1'b1);
        @(negedge clk);

        // ---------------- randomized run vs packet-level model ----------------
        picks[0] = 8'h01; picks[1] = 8'h02; picks[2] = 8'h03; picks[3] = 8'h04; picks[4] = 8'h55;
        pkt_left = 0; cyc = 0; stall = 0; pulses = 0; port_m = -1;
        in_pkt = 1'b0; hs = 1'b0; done = 1'b0;
        drops_before = exp_drops;
        while (!done) begin
            @(negedge clk);
            if (drop_pulse) pulses++;
            if (hs) s_tvalid = 1'b0;
            if ($urandom_range(7) == 0) begin
                for (int k = 0; k < 3; k++) tbl[k*8 +: 8] = 8'($urandom_range(1, 4));
                en = 3'($urandom);
            end
            o_tready = 3'($urandom);
            if (!s_tvalid && (pkt_left > 0 || cyc < 3000) && $urandom_range(3) != 0) begin
                if (pkt_left == 0) pkt_left = $urandom_range(1, 4);
                set_beat({$urandom, 24'($urandom), picks[$urandom_range(4)]}, pkt_left == 1);
            end
            #1;
            hs = s_tvalid && s_tready;
            chk("rnd_onehot", $countones(o_tvalid) <= 1, 1'b1);
            for (int k = 0; k < 3; k++) begin
                if (o_tvalid[k] && o_tready[k]) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd_unexpected_beat", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rnd_port", k, e.port);
                        chk("rnd_tdata", o_tdata, e.data);
                        chk("rnd_tlast", o_tlast, e.last);
                    end
                end
            end
            if (hs) begin
                if (!in_pkt) begin
                    port_m = ref_route(tbl, en, s_tdata[7:0]);
                    if (port_m < 0) exp_drops++;
                end
                if (port_m >= 0) exp_q.push_back('{port_m, s_tdata, s_tlast});
                in_pkt = !s_tlast;
                pkt_left--;
            end
            stall = (s_tvalid && !hs) ? stall + 1 : 0;
            if (stall > 200) begin
                chk("rnd_input_stall", stall, 0);
                done = 1'b1;
            end
            cyc++;
            if (cyc >= 3000 && pkt_left == 0 && exp_q.size() == 0) done = 1'b1;
            if (cyc > 20000) begin
                chk("rnd_timeout", exp_q.size(), 0);
                done = 1'b1;
            end
        end
        @(negedge clk);
        if (drop_pulse) pulses++;
        s_tvalid = 1'b0;
        @(negedge clk);
        if (drop_pulse) pulses++;
        chk("rnd_drop_count", drop_count, exp_drops);
        chk("rnd_drop_pulses", pulses, exp_drops - drops_before);
        chk("rnd_queue_empty", exp_q.size(), 0);
        chk("rnd_final_tvalid", o_tvalid, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
